m_console_keybuf: RTL and testbench

Keyboard receive buffer that sits directly upstream of the virtio console device. It captures bytes from the UART receiver into a show-ahead FIFO and raises a one-cycle `w_keyreq` toward the console, which sets the console IRQ and starts a micro-controller transfer. The micro-controller drains the FIFO through a pop handshake and signals completion. A hold-off timer then spaces successive requests.

---
 rtl/m_console_keybuf.sv | 160 ++++++++++++++++
 tb/tb_m_console_keybuf.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/m_console_keybuf.sv
// rtl/m_console_keybuf.sv - keyboard receive buffer with request/hold-off sequencing for the console
//
// Captures UART receive bytes into a show-ahead FIFO and issues a one-cycle
// request to the console whenever bytes are waiting and the micro-controller
// is idle. After the micro-controller signals completion, a hold-off timer
// spaces the next request.
//
// Parameters:
//   DEPTH    FIFO depth in bytes (power of two, >= 2)
//   HOLDOFF  idle cycles after a completed transfer before the next request (>= 1)
//
// Ports:
//   CLK         system clock
//   RST_X       asynchronous active-low reset
//   w_rx_valid  one-cycle strobe, byte on w_rx_data
//   w_rx_data   received byte
//   w_busy      micro-controller busy; blocks new requests (sampled in IDLE only)
//   w_pop       consume head byte this cycle
//   w_done      one-cycle strobe, transfer finished
//   w_clr_ovf   clear sticky overflow flag
//   w_keyreq    one-cycle request pulse to the console
//   w_rdata     head byte (show-ahead), valid when !w_empty
//   w_count     bytes stored, 0..DEPTH
//   w_empty     w_count == 0
//   w_full      w_count == DEPTH
//   w_overflow  sticky, a byte was dropped

module m_console_keybuf #(
  parameter int DEPTH   = 16,
  parameter int HOLDOFF = 64
) (
  input  logic                   CLK,
  input  logic                   RST_X,
  input  logic                   w_rx_valid,
  input  logic [7:0]             w_rx_data,
  input  logic                   w_busy,
  input  logic                   w_pop,
  input  logic                   w_done,
  input  logic                   w_clr_ovf,
  output logic                   w_keyreq,
  output logic [7:0]             w_rdata,
  output logic [$clog2(DEPTH):0] w_count,
  output logic                   w_empty,
  output logic                   w_full,
  output logic                   w_overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int HW = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_HOLD = 2'd3
  } state_t;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wp;
  logic [AW-1:0] rp;
  logic [CW-1:0] count_next;
  logic          push;
  logic          pop;
  logic          drop;

  state_t        state;
  logic [HW-1:0] hold_cnt;

  // A pop while full frees the slot the incoming byte needs, so a push is
  // accepted when full as long as it coincides with a pop.
  assign pop  = w_pop && !w_empty;
  assign push = w_rx_valid && (!w_full || w_pop);
  assign drop = w_rx_valid && w_full && !w_pop;

  assign w_rdata = mem[rp];

  always_comb begin
    count_next = w_count;
    case ({push, pop})
      2'b10:   count_next = w_count + CW'(1);
      2'b01:   count_next = w_count - CW'(1);
      default: count_next = w_count;
    endcase
  end

  // Storage has no reset; stale contents are never visible because count
  // gates every read.
  always_ff @(posedge CLK) begin
    if (push) begin
      mem[wp] <= w_rx_data;
    end
  end

  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X) begin
      wp         <= '0;
      rp         <= '0;
      w_count    <= '0;
      w_empty    <= 1'b1;
      w_full     <= 1'b0;
      w_overflow <= 1'b0;
    end else begin
      if (push) begin
        wp <= wp + AW'(1);
      end
      if (pop) begin
        rp <= rp + AW'(1);
      end
      w_count <= count_next;
      w_empty <= (count_next == '0);
      w_full  <= (count_next == CW'(DEPTH));
      // A drop in the same cycle as a clear keeps the flag set.
      if (drop) begin
        w_overflow <= 1'b1;
      end else if (w_clr_ovf) begin
        w_overflow <= 1'b0;
      end
    end
  end

  // Request sequencer. w_keyreq is registered and high exactly while in REQ.
  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X) begin
      state    <= S_IDLE;
      hold_cnt <= '0;
      w_keyreq <= 1'b0;
    end else begin
      w_keyreq <= 1'b0;
      case (state)
        S_IDLE: begin
          if (!w_empty && !w_busy) begin
            state    <= S_REQ;
            w_keyreq <= 1'b1;
          end
        end
        S_REQ: begin
          state <= S_WAIT;
        end
        S_WAIT: begin
          if (w_done) begin
            state    <= S_HOLD;
            hold_cnt <= HW'(HOLDOFF - 1);
          end
        end
        S_HOLD: begin
          if (hold_cnt == '0) begin
            state <= S_IDLE;
          end else begin
            hold_cnt <= hold_cnt - HW'(1);
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_m_console_keybuf.sv
// tb/tb_m_console_keybuf.sv - self-checking bench for m_console_keybuf

module tb_m_console_keybuf;

  localparam int DEPTH   = 16;
  localparam int HOLDOFF = 64;

  logic       CLK;
  logic       RST_X;
  logic       w_rx_valid;
  logic [7:0] w_rx_data;
  logic       w_busy;
  logic       w_pop;
  logic       w_done;
  logic       w_clr_ovf;
  logic       w_keyreq;
  logic [7:0] w_rdata;
  logic [4:0] w_count;
  logic       w_empty;
  logic       w_full;
  logic       w_overflow;

  int errors;
  int checks;
  int cyc;
  int kr_total;
  int kr_cycle;

  m_console_keybuf #(.DEPTH(DEPTH), .HOLDOFF(HOLDOFF)) dut (
    .CLK       (CLK),
    .RST_X     (RST_X),
    .w_rx_valid(w_rx_valid),
    .w_rx_data (w_rx_data),
    .w_busy    (w_busy),
    .w_pop     (w_pop),
    .w_done    (w_done),
    .w_clr_ovf (w_clr_ovf),
    .w_keyreq  (w_keyreq),
    .w_rdata   (w_rdata),
    .w_count   (w_count),
    .w_empty   (w_empty),
    .w_full    (w_full),
    .w_overflow(w_overflow)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  // Count request pulses, recording the cycle index at which each is seen.
  initial begin
    kr_total = 0;
    kr_cycle = -1;
  end
  always @(negedge CLK) begin
    if (RST_X && w_keyreq) begin
      kr_total = kr_total + 1;
      kr_cycle = cyc;
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs();
    w_rx_valid = 1'b0;
    w_rx_data  = 8'h00;
    w_busy     = 1'b0;
    w_pop      = 1'b0;
    w_done     = 1'b0;
    w_clr_ovf  = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    RST_X = 1'b0;
    tick();
    tick();
    RST_X = 1'b1;
    tick();
  endtask

  task automatic push_byte(input logic [7:0] b);
    w_rx_valid = 1'b1;
    w_rx_data  = b;
    tick();
    w_rx_valid = 1'b0;
  endtask

  task automatic pop_one();
    w_pop = 1'b1;
    tick();
    w_pop = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    RST_X = 1'b0;
    tick();
    tick();
    checks++; if (w_keyreq !== 1'b0) begin errors++; $display("FAIL reset_keyreq: got %0b expected 0", w_keyreq); end
    checks++; if (w_count !== 5'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", w_count); end
    checks++; if (w_empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %0b expected 1", w_empty); end
    checks++; if (w_full !== 1'b0) begin errors++; $display("FAIL reset_full: got %0b expected 0", w_full); end
    checks++; if (w_overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %0b expected 0", w_overflow); end
    RST_X = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    int base;
    int n;
    do_reset();
    base = kr_total;
    push_byte(8'h41);
    n = cyc;
    checks++; if (w_empty !== 1'b0) begin errors++; $display("FAIL basic_empty_after_push: got %0b expected 0", w_empty); end
    push_byte(8'h42);
    repeat (4) tick();
    checks++; if (kr_total - base !== 1) begin errors++; $display("FAIL basic_keyreq_count: got %0d expected 1", kr_total - base); end
    checks++; if (kr_cycle !== n + 1) begin errors++; $display("FAIL basic_keyreq_cycle: got %0d expected %0d", kr_cycle, n + 1); end
    checks++; if (w_rdata !== 8'h41) begin errors++; $display("FAIL basic_rdata0: got %0h expected 41", w_rdata); end
    checks++; if (w_count !== 5'd2) begin errors++; $display("FAIL basic_count2: got %0d expected 2", w_count); end
    pop_one();
    checks++; if (w_rdata !== 8'h42) begin errors++; $display("FAIL basic_rdata1: got %0h expected 42", w_rdata); end
    checks++; if (w_count !== 5'd1) begin errors++; $display("FAIL basic_count1: got %0d expected 1", w_count); end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 0; i < DEPTH; i++) push_byte(8'(i));
    checks++; if (w_overflow !== 1'b0) begin errors++; $display("FAIL ovf_before_drop: got %0b expected 0", w_overflow); end
    push_byte(8'hAA);
    checks++; if (w_full !== 1'b1) begin errors++; $display("FAIL ovf_full: got %0b expected 1", w_full); end
    checks++; if (w_overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %0b expected 1", w_overflow); end
    checks++; if (w_count !== 5'd16) begin errors++; $display("FAIL ovf_count: got %0d expected 16", w_count); end
    // drop and clear together: set wins
    w_clr_ovf = 1'b1;
    push_byte(8'hAB);
    w_clr_ovf = 1'b0;
    checks++; if (w_overflow !== 1'b1) begin errors++; $display("FAIL ovf_set_wins: got %0b expected 1", w_overflow); end
    w_clr_ovf = 1'b1;
    tick();
    w_clr_ovf = 1'b0;
    checks++; if (w_overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear: got %0b expected 0", w_overflow); end
    for (int i = 0; i < DEPTH; i++) begin
      checks++; if (w_rdata !== 8'(i)) begin errors++; $display("FAIL ovf_drain_%0d: got %0h expected %0h", i, w_rdata, i); end
      pop_one();
    end
    checks++; if (w_empty !== 1'b1) begin errors++; $display("FAIL ovf_drain_empty: got %0b expected 1", w_empty); end
  endtask

  task automatic test_full_pushpop();
    logic [7:0] exp_q[$];
    logic [7:0] e;
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      push_byte(8'h10 + 8'(i));
      exp_q.push_back(8'h10 + 8'(i));
    end
    w_rx_valid = 1'b1;
    w_rx_data  = 8'h55;
    w_pop      = 1'b1;
    tick();
    idle_inputs();
    void'(exp_q.pop_front());
    exp_q.push_back(8'h55);
    checks++; if (w_count !== 5'd16) begin errors++; $display("FAIL fpp_count: got %0d expected 16", w_count); end
    checks++; if (w_overflow !== 1'b0) begin errors++; $display("FAIL fpp_overflow: got %0b expected 0", w_overflow); end
    checks++; if (w_full !== 1'b1) begin errors++; $display("FAIL fpp_full: got %0b expected 1", w_full); end
    for (int i = 0; i < DEPTH; i++) begin
      e = exp_q.pop_front();
      checks++; if (w_rdata !== e) begin errors++; $display("FAIL fpp_drain_%0d: got %0h expected %0h", i, w_rdata, e); end
      pop_one();
    end
    checks++; if (w_empty !== 1'b1) begin errors++; $display("FAIL fpp_empty: got %0b expected 1", w_empty); end
    // push and pop together while empty: only the push lands
    w_rx_valid = 1'b1;
    w_rx_data  = 8'h66;
    w_pop      = 1'b1;
    tick();
    idle_inputs();
    checks++; if (w_count !== 5'd1) begin errors++; $display("FAIL epp_count: got %0d expected 1", w_count); end
    checks++; if (w_rdata !== 8'h66) begin errors++; $display("FAIL epp_rdata: got %0h expected 66", w_rdata); end
  endtask

  task automatic test_busy_holdoff();
    int base;
    int m;
    int d;
    int guard;
    do_reset();
    base = kr_total;
    w_busy = 1'b1;
    push_byte(8'h33);
    push_byte(8'h34);
    repeat (20) tick();
    checks++; if (kr_total - base !== 0) begin errors++; $display("FAIL busy_blocks: got %0d pulses expected 0", kr_total - base); end
    m = cyc;
    w_busy = 1'b0;
    repeat (3) tick();
    checks++; if (kr_total - base !== 1) begin errors++; $display("FAIL busy_release_count: got %0d expected 1", kr_total - base); end
    checks++; if (kr_cycle !== m + 1) begin errors++; $display("FAIL busy_release_cycle: got %0d expected %0d", kr_cycle, m + 1); end
    pop_one();
    tick();
    w_done = 1'b1;
    tick();
    d = cyc;
    w_done = 1'b0;
    guard = 0;
    while (kr_total - base < 2 && guard < 100) begin
      tick();
      guard++;
    end
    checks++; if (kr_total - base !== 2) begin errors++; $display("FAIL holdoff_count: got %0d expected 2", kr_total - base); end
    checks++; if (kr_cycle !== d + HOLDOFF + 1) begin errors++; $display("FAIL holdoff_cycle: got %0d expected %0d", kr_cycle, d + HOLDOFF + 1); end
    checks++; if (w_rdata !== 8'h34) begin errors++; $display("FAIL holdoff_rdata: got %0h expected 34", w_rdata); end
  endtask

  task automatic test_idle_ignore();
    int base;
    int n;
    do_reset();
    base = kr_total;
    w_pop  = 1'b1;
    w_done = 1'b1;
    tick();
    idle_inputs();
    checks++; if (w_count !== 5'd0) begin errors++; $display("FAIL ign_count: got %0d expected 0", w_count); end
    checks++; if (w_empty !== 1'b1) begin errors++; $display("FAIL ign_empty: got %0b expected 1", w_empty); end
    repeat (5) tick();
    checks++; if (kr_total - base !== 0) begin errors++; $display("FAIL ign_no_keyreq: got %0d expected 0", kr_total - base); end
    // the FSM must still be in IDLE, so a push requests without hold-off
    push_byte(8'h77);
    n = cyc;
    repeat (3) tick();
    checks++; if (kr_cycle !== n + 1) begin errors++; $display("FAIL ign_then_req: got %0d expected %0d", kr_cycle, n + 1); end
    checks++; if (w_rdata !== 8'h77) begin errors++; $display("FAIL ign_rdata: got %0h expected 77", w_rdata); end
  endtask

  task automatic test_async_reset();
    int base;
    int n;
    do_reset();
    for (int i = 0; i < 5; i++) push_byte(8'hC0 + 8'(i));
    repeat (3) tick();
    checks++; if (w_count !== 5'd5) begin errors++; $display("FAIL ar_count_before: got %0d expected 5", w_count); end
    @(posedge CLK);
    #3;
    RST_X = 1'b0;
    #1;
    checks++; if (w_count !== 5'd0) begin errors++; $display("FAIL ar_count: got %0d expected 0", w_count); end
    checks++; if (w_empty !== 1'b1) begin errors++; $display("FAIL ar_empty: got %0b expected 1", w_empty); end
    checks++; if (w_keyreq !== 1'b0) begin errors++; $display("FAIL ar_keyreq: got %0b expected 0", w_keyreq); end
    checks++; if (w_full !== 1'b0 || w_overflow !== 1'b0) begin errors++; $display("FAIL ar_flags: got full=%0b ovf=%0b expected 0 0", w_full, w_overflow); end
    tick();
    RST_X = 1'b1;
    base = kr_total;
    repeat (20) tick();
    checks++; if (kr_total - base !== 0) begin errors++; $display("FAIL ar_no_keyreq: got %0d expected 0", kr_total - base); end
    push_byte(8'h99);
    n = cyc;
    repeat (3) tick();
    checks++; if (kr_total - base !== 1 || kr_cycle !== n + 1) begin errors++; $display("FAIL ar_new_req: got %0d pulses at %0d expected 1 at %0d", kr_total - base, kr_cycle, n + 1); end
  endtask

  task automatic test_random();
    logic [7:0] q[$];
    logic       ovf_m;
    logic       rx;
    logic       pp;
    logic       clr;
    logic       full_m;
    logic [7:0] d;
    do_reset();
    ovf_m = 1'b0;
    for (int i = 0; i < 400; i++) begin
      rx  = ($urandom % 2) == 0;
      pp  = (i < 200) ? (($urandom % 3) == 0) : (($urandom % 3) != 0);
      clr = ($urandom % 16) == 0;
      d   = 8'($urandom);
      w_rx_valid = rx;
      w_rx_data  = d;
      w_pop      = pp;
      w_clr_ovf  = clr;
      w_busy     = ($urandom % 4) == 0;
      w_done     = ($urandom % 10) == 0;
      full_m = (q.size() == DEPTH);
      if (rx && full_m && !pp) ovf_m = 1'b1;
      else if (clr) ovf_m = 1'b0;
      if (pp && q.size() > 0) void'(q.pop_front());
      if (rx && (!full_m || pp)) q.push_back(d);
      tick();
      checks++; if (w_count !== 5'(q.size())) begin errors++; $display("FAIL rnd_count@%0d: got %0d expected %0d", i, w_count, q.size()); end
      checks++; if (w_empty !== (q.size() == 0) || w_full !== (q.size() == DEPTH)) begin errors++; $display("FAIL rnd_flags@%0d: got e=%0b f=%0b size %0d", i, w_empty, w_full, q.size()); end
      checks++; if (w_overflow !== ovf_m) begin errors++; $display("FAIL rnd_ovf@%0d: got %0b expected %0b", i, w_overflow, ovf_m); end
      if (q.size() > 0) begin
        checks++; if (w_rdata !== q[0]) begin errors++; $display("FAIL rnd_rdata@%0d: got %0h expected %0h", i, w_rdata, q[0]); end
      end
    end
    idle_inputs();
  endtask

  initial begin
    errors = 0;
    checks = 0;
    RST_X  = 1'b0;
    idle_inputs();
    test_reset();
    test_basic();
    test_overflow();
    test_full_pushpop();
    test_busy_holdoff();
    test_idle_ignore();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
